// File: rtl/phys_reg_alloc_ctrl.sv
// Rename-stage free-list controller: initial fill of unmapped tags, allocation with
// one-cycle cancel rollback, round-robin release arbitration and a free-register count.
module phys_reg_alloc_ctrl #(
    parameter int NUM_ARCH = 32,
    parameter int NUM_PHYS = 64,
    localparam int DEPTH = NUM_PHYS - NUM_ARCH,
    localparam int TW = $clog2(NUM_PHYS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          alloc_req,
    output logic          alloc_ready,
    output logic [TW-1:0] alloc_tag,
    input  logic          alloc_cancel,
    input  logic          rel_ret_valid,
    input  logic [TW-1:0] rel_ret_tag,
    output logic          rel_ret_ready,
    input  logic          rel_sq_valid,
    input  logic [TW-1:0] rel_sq_tag,
    output logic          rel_sq_ready,
    output logic          fl_push,
    output logic          fl_potential_push,
    output logic          fl_pop,
    output logic          fl_rollback,
    output logic [TW-1:0] fl_data_in,
    input  logic          fl_valid,
    input  logic          fl_full,
    input  logic [TW-1:0] fl_data_out,
    output logic [TW:0]   free_count,
    output logic          init_done
);

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state, state_nxt;
    logic [TW-1:0] init_cnt;
    logic          prio_sq;
    logic          last_pop;
    logic          sel_sq;

    // Count update; the clamp only guards against an illegal push/rollback overlap.
    function automatic logic [TW:0] fc_next(input logic [TW:0] fc, input logic push,
                                            input logic pop, input logic rb);
        logic [TW+1:0] sum;
        sum = {1'b0, fc} + {{(TW+1){1'b0}}, push} + {{(TW+1){1'b0}}, rb}
              - {{(TW+1){1'b0}}, pop};
        if (sum > (TW+2)'(DEPTH))
            sum = (TW+2)'(DEPTH);
        return sum[TW:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_INIT;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (state == S_INIT && init_cnt == TW'(DEPTH - 1))
            state_nxt = S_RUN;
    end

    always_comb begin
        alloc_ready       = 1'b0;
        alloc_tag         = fl_data_out;
        fl_pop            = 1'b0;
        fl_rollback       = 1'b0;
        fl_push           = 1'b0;
        fl_potential_push = 1'b0;
        fl_data_in        = '0;
        rel_ret_ready     = 1'b0;
        rel_sq_ready      = 1'b0;
        sel_sq            = 1'b0;
        if (state == S_INIT) begin
            fl_push           = 1'b1;
            fl_potential_push = 1'b1;
            fl_data_in        = TW'(NUM_ARCH) + init_cnt;
        end else begin
            // Cancel cycle blocks allocation so pop and rollback never overlap.
            alloc_ready       = fl_valid & (free_count != '0) & ~alloc_cancel;
            fl_pop            = alloc_req & alloc_ready;
            fl_rollback       = alloc_cancel & last_pop;
            sel_sq            = (rel_ret_valid & rel_sq_valid) ? prio_sq : rel_sq_valid;
            fl_potential_push = rel_ret_valid | rel_sq_valid;
            fl_data_in        = sel_sq ? rel_sq_tag : rel_ret_tag;
            fl_push           = fl_potential_push & (~fl_full | fl_pop);
            rel_ret_ready     = fl_push & ~sel_sq;
            rel_sq_ready      = fl_push & sel_sq;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            init_cnt   <= '0;
            free_count <= '0;
            init_done  <= 1'b0;
            prio_sq    <= 1'b0;
            last_pop   <= 1'b0;
        end else begin
            if (state == S_INIT)
                init_cnt <= init_cnt + TW'(1);
            init_done  <= (state_nxt == S_RUN);
            free_count <= fc_next(free_count, fl_push, fl_pop, fl_rollback);
            // Pointer only moves on contested grants.
            if (state == S_RUN && rel_ret_valid && rel_sq_valid && fl_push)
                prio_sq <= ~prio_sq;
            last_pop   <= fl_pop;
        end
    end

endmodule

// File: tb/tb_phys_reg_alloc_ctrl.sv
// Bench for phys_reg_alloc_ctrl: a queue-based free list plus a rule-level model of the
// controller, compared every cycle, with directed scenarios and a randomized phase.
module tb_phys_reg_alloc_ctrl;

    localparam int NUM_ARCH = 32;
    localparam int NUM_PHYS = 64;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int TW       = $clog2(NUM_PHYS);

    typedef logic [TW-1:0] tag_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        alloc_req = 1'b0, alloc_cancel = 1'b0;
    logic        alloc_ready;
    tag_t        alloc_tag;
    logic        rel_ret_valid = 1'b0, rel_sq_valid = 1'b0;
    tag_t        rel_ret_tag = '0, rel_sq_tag = '0;
    logic        rel_ret_ready, rel_sq_ready;
    logic        fl_push, fl_potential_push, fl_pop, fl_rollback;
    tag_t        fl_data_in;
    logic        fl_valid = 1'b0, fl_full = 1'b0;
    tag_t        fl_data_out = '0;
    logic [TW:0] free_count;
    logic        init_done;

    phys_reg_alloc_ctrl #(.NUM_ARCH(NUM_ARCH), .NUM_PHYS(NUM_PHYS)) dut (
        .clk(clk), .rst(rst),
        .alloc_req(alloc_req), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .alloc_cancel(alloc_cancel),
        .rel_ret_valid(rel_ret_valid), .rel_ret_tag(rel_ret_tag), .rel_ret_ready(rel_ret_ready),
        .rel_sq_valid(rel_sq_valid), .rel_sq_tag(rel_sq_tag), .rel_sq_ready(rel_sq_ready),
        .fl_push(fl_push), .fl_potential_push(fl_potential_push), .fl_pop(fl_pop),
        .fl_rollback(fl_rollback), .fl_data_in(fl_data_in),
        .fl_valid(fl_valid), .fl_full(fl_full), .fl_data_out(fl_data_out),
        .free_count(free_count), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Free-list contents (head at index 0) and model state, committed after each edge.
    tag_t q[$], q_n[$];
    int   m_cyc = 0, m_cyc_n = 0;
    bit   m_sq_turn = 0, m_sq_turn_n = 0;
    bit   m_lastpop = 0, m_lastpop_n = 0;
    bit   m_prev_push = 0, m_prev_push_n = 0;
    tag_t m_last_tag = '0, m_last_tag_n = '0;
    tag_t grant_log[$];

    always @(negedge clk) begin : compare
        bit   e_ar, e_pop, e_rb, e_push, e_pot, e_rr, e_sr, e_done, sel_sq, both;
        tag_t e_din, popped;
        e_ar = 0; e_pop = 0; e_rb = 0; e_push = 0; e_pot = 0; e_rr = 0; e_sr = 0;
        e_done = 0; sel_sq = 0; both = 0; e_din = '0;
        m_sq_turn_n  = m_sq_turn;
        m_last_tag_n = m_last_tag;
        q_n = q;
        if (!rst) begin
            q_n.delete();
            m_cyc_n = 0; m_sq_turn_n = 0; m_lastpop_n = 0; m_prev_push_n = 0;
        end else begin
            if (m_cyc < DEPTH) begin
                e_push = 1; e_pot = 1;
                e_din  = tag_t'(NUM_ARCH + m_cyc);
                q_n.push_back(e_din);
                m_cyc_n = m_cyc + 1;
            end else begin
                m_cyc_n = m_cyc;
                e_done  = 1;
                e_ar    = (q.size() != 0) && !alloc_cancel;
                e_pop   = alloc_req && e_ar;
                e_rb    = alloc_cancel && m_lastpop;
                both    = rel_ret_valid && rel_sq_valid;
                sel_sq  = both ? m_sq_turn : rel_sq_valid;
                e_pot   = rel_ret_valid || rel_sq_valid;
                e_push  = e_pot && ((q.size() < DEPTH) || e_pop);
                e_din   = sel_sq ? rel_sq_tag : rel_ret_tag;
                e_rr    = e_push && !sel_sq;
                e_sr    = e_push && sel_sq;
                if (e_pop) begin
                    popped = q_n.pop_front();
                    m_last_tag_n = popped;
                end
                if (e_rb)   q_n.push_front(m_last_tag);
                if (e_push) q_n.push_back(e_din);
                if (both && e_push) m_sq_turn_n = !m_sq_turn;
            end
            m_lastpop_n   = e_pop;
            m_prev_push_n = e_push;

            check("init_done", init_done, e_done);
            check("free_count", free_count, q.size());
            check("alloc_ready", alloc_ready, e_ar);
            check("fl_pop", fl_pop, e_pop);
            check("fl_rollback", fl_rollback, e_rb);
            check("fl_potential_push", fl_potential_push, e_pot);
            check("fl_push", fl_push, e_push);
            check("rel_ret_ready", rel_ret_ready, e_rr);
            check("rel_sq_ready", rel_sq_ready, e_sr);
            if (e_ar)  check("alloc_tag", alloc_tag, q[0]);
            if (e_pot) check("fl_data_in", fl_data_in, e_din);
            if (m_cyc == 0) check("first_fill_tag", fl_data_in, 32);
            if (m_cyc == DEPTH && m_cyc_n == DEPTH && q.size() == DEPTH && !fl_pop && !fl_push) begin
                check("fill_done_flag", init_done, 1);
                check("fill_done_count", free_count, 32);
            end
            if (alloc_req && alloc_ready) grant_log.push_back(alloc_tag);
        end
    end

    always @(posedge clk) begin
        #1;
        q = q_n;
        m_cyc = m_cyc_n; m_sq_turn = m_sq_turn_n; m_lastpop = m_lastpop_n;
        m_prev_push = m_prev_push_n; m_last_tag = m_last_tag_n;
        fl_valid    = (q.size() != 0);
        fl_full     = (q.size() == DEPTH);
        fl_data_out = (q.size() != 0) ? q[0] : '0;
    end

    task automatic cyc(input bit r, input bit req, input bit can,
                       input bit rv, input tag_t rt, input bit sv, input tag_t st);
        @(posedge clk);
        #2;
        rst = r; alloc_req = req; alloc_cancel = can;
        rel_ret_valid = rv; rel_ret_tag = rt; rel_sq_valid = sv; rel_sq_tag = st;
        @(negedge clk);
    endtask

    task automatic run_idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, '0, 0, '0);
    endtask

    task automatic fresh_fill();
        repeat (2) cyc(0, 0, 0, 0, '0, 0, '0);
        cyc(1, 0, 0, 0, '0, 0, '0);
        run_idle(DEPTH);
    endtask

    initial begin : stim
        tag_t rt, st;
        bit   ret_v, sq_v, ret_acc, sq_acc, r, req, can;

        // Fill, then drain with back-to-back allocations.
        repeat (1) cyc(0, 0, 0, 0, '0, 0, '0);
        fresh_fill();
        grant_log.delete();
        repeat (DEPTH + 2) cyc(1, 1, 0, 0, '0, 0, '0);
        check("drain_grants", grant_log.size(), 32);
        for (int i = 0; i < grant_log.size(); i++) check("drain_tag", grant_log[i], 32 + i);
        check("drain_ready", alloc_ready, 0);
        check("drain_count", free_count, 0);

        // Cancel of tag 40, re-grant, then a cancel with no preceding pop.
        fresh_fill();
        repeat (9) cyc(1, 1, 0, 0, '0, 0, '0);
        check("pre_cancel_tag", alloc_tag, 40);
        cyc(1, 0, 1, 0, '0, 0, '0);
        check("cancel_rollback", fl_rollback, 1);
        check("cancel_ready", alloc_ready, 0);
        cyc(1, 1, 0, 0, '0, 0, '0);
        check("regrant_tag", alloc_tag, 40);
        check("regrant_ready", alloc_ready, 1);
        check("regrant_count", free_count, 24);
        cyc(1, 0, 0, 0, '0, 0, '0);
        check("after_regrant_count", free_count, 23);
        cyc(1, 0, 1, 0, '0, 0, '0);
        check("stray_cancel_rollback", fl_rollback, 0);
        cyc(1, 0, 0, 0, '0, 0, '0);
        check("stray_cancel_count", free_count, 23);

        // Reset in the middle of the fill restarts it from tag 32.
        repeat (2) cyc(0, 0, 0, 0, '0, 0, '0);
        cyc(1, 0, 0, 0, '0, 0, '0);
        run_idle(9);
        cyc(0, 0, 0, 0, '0, 0, '0);
        cyc(1, 0, 0, 0, '0, 0, '0);
        check("refill_tag", fl_data_in, 32);
        check("refill_push", fl_push, 1);
        check("refill_count", free_count, 0);
        run_idle(DEPTH);
        check("refill_done_count", free_count, 32);
        check("refill_done_flag", init_done, 1);

        // Contested releases on a full list with continuous allocation.
        rt = 6'd1; st = 6'd11;
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 1, rt, 1, st);
            check("rr_sq_grant", rel_sq_ready, (i % 2));
            check("rr_ret_grant", rel_ret_ready, 1 - (i % 2));
            check("rr_count", free_count, 32);
            if (rel_ret_ready) rt = rt + 6'd1;
            if (rel_sq_ready)  st = st + 6'd1;
        end
        run_idle(2);

        // Randomized traffic with holding losers, occasional cancels and resets.
        ret_v = 0; sq_v = 0; ret_acc = 0; sq_acc = 0; rt = '0; st = '0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #2;
            r = ($urandom_range(299) != 0);
            if (!ret_v || ret_acc) begin
                ret_v = ($urandom_range(2) == 0);
                rt    = tag_t'($urandom_range(NUM_PHYS - 1));
            end
            if (!sq_v || sq_acc) begin
                sq_v = ($urandom_range(2) == 0);
                st   = tag_t'($urandom_range(NUM_PHYS - 1));
            end
            req = ($urandom_range(4) < 3);
            can = ($urandom_range(5) == 0) && (q.size() <= DEPTH - 2) && !m_prev_push;
            rst = r; alloc_req = req; alloc_cancel = can;
            rel_ret_valid = ret_v; rel_ret_tag = rt; rel_sq_valid = sq_v; rel_sq_tag = st;
            @(negedge clk);
            ret_acc = rel_ret_valid && rel_ret_ready;
            sq_acc  = rel_sq_valid && rel_sq_ready;
        end
        run_idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
